// File: rtl/mcu_packet_scheduler_if.sv
// MCU-side handshake bundle between the packet scheduler (slave) and the
// MCU LOAD logic plus SPI byte shifter (master).
interface mcu_packet_scheduler_if;
  logic       load;
  logic       done;
  logic       byte_rd;
  logic [7:0] tx_byte;
  logic       tx_last;
  logic       overrun;

  modport slave (
    input  load,
    input  byte_rd,
    output done,
    output tx_byte,
    output tx_last,
    output overrun
  );

  modport master (
    output load,
    output byte_rd,
    input  done,
    input  tx_byte,
    input  tx_last,
    input  overrun
  );
endinterface

// File: rtl/mcu_packet_scheduler.sv
// Latches sensor samples, snapshots them into a 32-byte packet and feeds it
// to the MCU SPI shifter one byte per byte_rd once LOAD rises.
module mcu_packet_scheduler #(
  parameter logic [7:0] HEADER    = 8'hAA,
  parameter int         PKT_BYTES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  quat1_valid,
  input  logic [63:0]           quat1_data,
  input  logic                  gyro1_valid,
  input  logic [47:0]           gyro1_data,
  input  logic                  quat2_valid,
  input  logic [63:0]           quat2_data,
  input  logic                  gyro2_valid,
  input  logic [47:0]           gyro2_data,
  mcu_packet_scheduler_if.slave mcu
);

  typedef enum logic [2:0] {IDLE, CAPTURE, READY, SEND, DRAIN} state_t;

  state_t       state;
  logic [63:0]  q1_shadow;
  logic [63:0]  q2_shadow;
  logic [47:0]  g1_shadow;
  logic [47:0]  g2_shadow;
  logic [3:0]   sticky;
  logic [3:0]   sample_valid;
  logic [247:0] body_live;
  logic [247:0] snap_body;
  logic [7:0]   snap_csum;
  logic [255:0] packet;
  logic [4:0]   idx;
  logic [4:0]   idx_inc;
  logic [7:0]   next_byte;
  logic         load_d;
  logic         load_rise;
  logic         load_fall;
  logic         pending;
  logic         done_r;
  logic         tx_last_r;
  logic         overrun_r;
  logic [7:0]   tx_byte_r;

  function automatic logic [7:0] xor_bytes(input logic [247:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) acc ^= v[i*8 +: 8];
    return acc;
  endfunction

  // Sticky bit order matches sample_valid: {g2, q2, g1, q1}.
  assign sample_valid = {gyro2_valid, quat2_valid, gyro1_valid, quat1_valid};
  assign body_live    = {HEADER, q1_shadow, g1_shadow, 6'b0, sticky[1], sticky[0],
                         q2_shadow, g2_shadow, 6'b0, sticky[3], sticky[2]};
  assign packet       = {snap_body, snap_csum};
  assign idx_inc      = idx + 5'd1;
  // Byte n sits at bit 255-8n; ~idx_inc is 31-idx_inc in five bits.
  assign next_byte    = packet[{~idx_inc, 3'b000} +: 8];
  assign load_rise    = mcu.load & ~load_d;
  assign load_fall    = ~mcu.load & load_d;
  assign pending      = (|sticky) | (|sample_valid);

  assign mcu.done     = done_r;
  assign mcu.tx_byte  = tx_byte_r;
  assign mcu.tx_last  = tx_last_r;
  assign mcu.overrun  = overrun_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      q1_shadow <= '0;
      g1_shadow <= '0;
      q2_shadow <= '0;
      g2_shadow <= '0;
    end else begin
      if (quat1_valid) q1_shadow <= quat1_data;
      if (gyro1_valid) g1_shadow <= gyro1_data;
      if (quat2_valid) q2_shadow <= quat2_data;
      if (gyro2_valid) g2_shadow <= gyro2_data;
    end
  end

  // A sample arriving during CAPTURE re-sets its sticky bit after the clear,
  // so it is carried into the next packet instead of being lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sticky    <= '0;
      snap_body <= '0;
      snap_csum <= '0;
      idx       <= '0;
      load_d    <= 1'b0;
      done_r    <= 1'b0;
      tx_byte_r <= 8'h00;
      tx_last_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      load_d <= mcu.load;
      sticky <= ((state == CAPTURE) ? 4'b0000 : sticky) | sample_valid;
      case (state)
        IDLE: begin
          if (pending) state <= CAPTURE;
        end
        CAPTURE: begin
          snap_body <= body_live;
          snap_csum <= xor_bytes(body_live);
          done_r    <= 1'b1;
          state     <= READY;
        end
        READY: begin
          if (load_rise) begin
            idx       <= 5'd0;
            tx_byte_r <= packet[255:248];
            tx_last_r <= 1'b0;
            done_r    <= 1'b0;
            state     <= SEND;
          end else if (pending && !mcu.load) begin
            state <= CAPTURE;
          end
        end
        SEND: begin
          if (load_fall) begin
            tx_byte_r <= 8'h00;
            tx_last_r <= 1'b0;
            state     <= IDLE;
          end else if (mcu.byte_rd) begin
            if (idx == 5'd31) begin
              tx_byte_r <= 8'h00;
              tx_last_r <= 1'b0;
              state     <= DRAIN;
            end else begin
              idx       <= idx_inc;
              tx_byte_r <= next_byte;
              tx_last_r <= (idx_inc == 5'd31);
            end
          end
        end
        DRAIN: begin
          if (mcu.byte_rd) overrun_r <= 1'b1;
          if (!mcu.load) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (PKT_BYTES == 32 && int'(idx) < PKT_BYTES);
  end

endmodule

// File: tb/tb_mcu_packet_scheduler.sv
// Bench for mcu_packet_scheduler: a packet-level reference model checked every
// cycle, plus literal expectations from hand-computed packets.
module tb_mcu_packet_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        quat1_valid;
  logic [63:0] quat1_data;
  logic        gyro1_valid;
  logic [47:0] gyro1_data;
  logic        quat2_valid;
  logic [63:0] quat2_data;
  logic        gyro2_valid;
  logic [47:0] gyro2_data;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  logic [7:0] rx  [34];
  logic [7:0] rxl [34];
  int         rx_count;

  always #5 clk = ~clk;

  mcu_packet_scheduler_if bus();

  mcu_packet_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .quat1_valid (quat1_valid),
    .quat1_data  (quat1_data),
    .gyro1_valid (gyro1_valid),
    .gyro1_data  (gyro1_data),
    .quat2_valid (quat2_valid),
    .quat2_data  (quat2_data),
    .gyro2_valid (gyro2_valid),
    .gyro2_data  (gyro2_data),
    .mcu         (bus)
  );

  typedef enum {M_IDLE, M_CAPTURE, M_READY, M_SEND, M_DRAIN} mphase_t;

  mphase_t     m_phase;
  logic [63:0] m_q1, m_q2;
  logic [47:0] m_g1, m_g2;
  logic [3:0]  m_sticky;
  logic [7:0]  m_packet [32];
  logic [7:0]  m_txq [$];
  logic        m_load_prev;
  logic        exp_done, exp_last, exp_overrun;
  logic [7:0]  exp_tx;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // k-th 16-bit field counted from the MSB of an n-field word.
  function automatic logic [15:0] field(input logic [63:0] v, input int n, input int k);
    logic [63:0] tmp;
    tmp = v >> (16 * (n - 1 - k));
    return tmp[15:0];
  endfunction

  function automatic void buildPacket(input logic [3:0] st);
    int p;
    logic [15:0] f;
    logic [7:0] csum;
    p = 0;
    m_packet[p] = 8'hAA; p++;
    for (int k = 0; k < 4; k++) begin f = field(m_q1, 4, k); m_packet[p] = f[15:8]; p++; m_packet[p] = f[7:0]; p++; end
    for (int k = 0; k < 3; k++) begin f = field({16'h0, m_g1}, 3, k); m_packet[p] = f[15:8]; p++; m_packet[p] = f[7:0]; p++; end
    m_packet[p] = {6'b0, st[1], st[0]}; p++;
    for (int k = 0; k < 4; k++) begin f = field(m_q2, 4, k); m_packet[p] = f[15:8]; p++; m_packet[p] = f[7:0]; p++; end
    for (int k = 0; k < 3; k++) begin f = field({16'h0, m_g2}, 3, k); m_packet[p] = f[15:8]; p++; m_packet[p] = f[7:0]; p++; end
    m_packet[p] = {6'b0, st[3], st[2]}; p++;
    csum = 8'h00;
    for (int i = 0; i < 31; i++) csum ^= m_packet[i];
    m_packet[31] = csum;
  endfunction

  // Reference model: packet built as a byte array, sent from a queue.
  always @(posedge clk) begin : model
    logic [3:0] v;
    logic rise, fall, pend, clear;
    if (reset) begin
      m_phase = M_IDLE;
      m_q1 = '0; m_q2 = '0; m_g1 = '0; m_g2 = '0;
      m_sticky = '0;
      m_txq.delete();
      m_load_prev = 1'b0;
      exp_done = 1'b0; exp_last = 1'b0; exp_overrun = 1'b0; exp_tx = 8'h00;
    end else begin
      v     = {gyro2_valid, quat2_valid, gyro1_valid, quat1_valid};
      rise  = bus.load && !m_load_prev;
      fall  = !bus.load && m_load_prev;
      pend  = (m_sticky != 4'b0) || (v != 4'b0);
      clear = 1'b0;
      case (m_phase)
        M_IDLE: if (pend) m_phase = M_CAPTURE;
        M_CAPTURE: begin
          buildPacket(m_sticky);
          clear = 1'b1;
          exp_done = 1'b1;
          m_phase = M_READY;
        end
        M_READY: begin
          if (rise) begin
            m_txq.delete();
            for (int i = 0; i < 32; i++) m_txq.push_back(m_packet[i]);
            exp_tx = m_txq.pop_front();
            exp_last = 1'b0;
            exp_done = 1'b0;
            m_phase = M_SEND;
          end else if (pend && !bus.load) begin
            m_phase = M_CAPTURE;
          end
        end
        M_SEND: begin
          if (fall) begin
            exp_tx = 8'h00; exp_last = 1'b0; m_phase = M_IDLE;
          end else if (bus.byte_rd) begin
            if (m_txq.size() == 0) begin
              exp_tx = 8'h00; exp_last = 1'b0; m_phase = M_DRAIN;
            end else begin
              exp_tx = m_txq.pop_front();
              exp_last = (m_txq.size() == 0);
            end
          end
        end
        M_DRAIN: begin
          if (bus.byte_rd) exp_overrun = 1'b1;
          if (!bus.load) m_phase = M_IDLE;
        end
        default: m_phase = M_IDLE;
      endcase
      m_sticky = (clear ? 4'b0 : m_sticky) | v;
      if (quat1_valid) m_q1 = quat1_data;
      if (gyro1_valid) m_g1 = gyro1_data;
      if (quat2_valid) m_q2 = quat2_data;
      if (gyro2_valid) m_g2 = gyro2_data;
      m_load_prev = bus.load;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("cmp_done",    {7'b0, bus.done},    {7'b0, exp_done});
      checkOutput("cmp_tx_byte", bus.tx_byte,         exp_tx);
      checkOutput("cmp_tx_last", {7'b0, bus.tx_last}, {7'b0, exp_last});
      checkOutput("cmp_overrun", {7'b0, bus.overrun}, {7'b0, exp_overrun});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] valids, input logic [63:0] q1, input logic [47:0] g1,
                               input logic [63:0] q2, input logic [47:0] g2);
    quat1_valid = valids[0]; quat1_data = q1;
    gyro1_valid = valids[1]; gyro1_data = g1;
    quat2_valid = valids[2]; quat2_data = q2;
    gyro2_valid = valids[3]; gyro2_data = g2;
    tick(1);
    quat1_valid = 1'b0; gyro1_valid = 1'b0; quat2_valid = 1'b0; gyro2_valid = 1'b0;
  endtask

  task automatic startSend();
    bus.load = 1'b1;
    tick(1);
    rx_count = 0;
    rx[0]  = bus.tx_byte;
    rxl[0] = {7'b0, bus.tx_last};
  endtask

  task automatic readBytes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.byte_rd = 1'b1;
      tick(1);
      rx_count++;
      if (rx_count < 34) begin
        rx[rx_count]  = bus.tx_byte;
        rxl[rx_count] = {7'b0, bus.tx_last};
      end
    end
    bus.byte_rd = 1'b0;
  endtask

  task automatic endSend();
    bus.load = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    quat1_valid = 1'b0; quat1_data = '0;
    gyro1_valid = 1'b0; gyro1_data = '0;
    quat2_valid = 1'b0; quat2_data = '0;
    gyro2_valid = 1'b0; gyro2_data = '0;
    bus.load = 1'b0;
    bus.byte_rd = 1'b0;
    tick(2);
    model_live = 1'b1;
    checkOutput("reset_done",    {7'b0, bus.done},    8'h00);
    checkOutput("reset_tx_byte", bus.tx_byte,         8'h00);
    checkOutput("reset_overrun", {7'b0, bus.overrun}, 8'h00);
    reset = 1'b0;
    tick(2);

    $display("[TB] test 1: all sources, full packet");
    applyStimulus(4'hF, {16'h4000, 16'h1000, 16'h2000, 16'h3000}, {16'h0100, 16'h0200, 16'h0300},
                  {16'h5000, 48'h0}, 48'h0);
    checkOutput("t1_done_capture", {7'b0, bus.done}, 8'h00);
    tick(1);
    checkOutput("t1_done_latency", {7'b0, bus.done}, 8'h01);
    startSend();
    readBytes(31);
    checkOutput("t1_byte0",  rx[0],  8'hAA);
    checkOutput("t1_byte1",  rx[1],  8'h40);
    checkOutput("t1_byte2",  rx[2],  8'h00);
    checkOutput("t1_byte15", rx[15], 8'h03);
    checkOutput("t1_byte16", rx[16], 8'h50);
    checkOutput("t1_byte30", rx[30], 8'h03);
    checkOutput("t1_byte31", rx[31], 8'hBA);
    checkOutput("t1_last30", rxl[30], 8'h00);
    checkOutput("t1_last31", rxl[31], 8'h01);
    endSend();

    $display("[TB] test 2: quat1 only");
    applyStimulus(4'h1, {16'h6000, 48'h0}, 48'h0, 64'h0, 48'h0);
    tick(1);
    checkOutput("t2_done", {7'b0, bus.done}, 8'h01);
    startSend();
    checkOutput("t2_done_drop", {7'b0, bus.done}, 8'h00);
    readBytes(31);
    checkOutput("t2_byte1",  rx[1],  8'h60);
    checkOutput("t2_byte9",  rx[9],  8'h01);
    checkOutput("t2_byte15", rx[15], 8'h01);
    checkOutput("t2_byte30", rx[30], 8'h00);
    endSend();

    $display("[TB] test 3: refresh in READY");
    applyStimulus(4'h1, {16'h6000, 48'h0}, 48'h0, 64'h0, 48'h0);
    tick(1);
    applyStimulus(4'h8, 64'h0, 48'h0, 64'h0, {16'd400, 32'h0});
    checkOutput("t3_done_hold0", {7'b0, bus.done}, 8'h01);
    tick(1);
    checkOutput("t3_done_hold1", {7'b0, bus.done}, 8'h01);
    tick(1);
    startSend();
    readBytes(31);
    checkOutput("t3_byte15", rx[15], 8'h00);
    checkOutput("t3_byte16", rx[16], 8'h50);
    checkOutput("t3_byte24", rx[24], 8'h01);
    checkOutput("t3_byte25", rx[25], 8'h90);
    checkOutput("t3_byte30", rx[30], 8'h02);
    endSend();

    $display("[TB] test 4: abort mid-packet with a pending sample");
    applyStimulus(4'h4, 64'h0, 48'h0, {16'h7000, 48'h0}, 48'h0);
    tick(1);
    startSend();
    readBytes(10);
    applyStimulus(4'h2, 64'h0, {16'h0A0B, 32'h0}, 64'h0, 48'h0);
    bus.load = 1'b0;
    tick(1);
    checkOutput("t4_abort_done", {7'b0, bus.done}, 8'h00);
    tick(1);
    checkOutput("t4_capture_done", {7'b0, bus.done}, 8'h00);
    tick(1);
    checkOutput("t4_refresh_done", {7'b0, bus.done}, 8'h01);

    $display("[TB] test 5: overrun past byte 31");
    startSend();
    readBytes(33);
    checkOutput("t5_byte9",   rx[9],   8'h0A);
    checkOutput("t5_last31",  rxl[31], 8'h01);
    checkOutput("t5_last32",  rxl[32], 8'h00);
    checkOutput("t5_byte32",  rx[32],  8'h00);
    checkOutput("t5_byte33",  rx[33],  8'h00);
    checkOutput("t5_overrun", {7'b0, bus.overrun}, 8'h01);
    endSend();
    checkOutput("t5_overrun_sticky", {7'b0, bus.overrun}, 8'h01);

    $display("[TB] test 6: reset during SEND");
    applyStimulus(4'h1, {16'h1234, 48'h0}, 48'h0, 64'h0, 48'h0);
    tick(1);
    startSend();
    readBytes(12);
    reset = 1'b1;
    tick(1);
    checkOutput("t6_done",    {7'b0, bus.done},    8'h00);
    checkOutput("t6_tx_byte", bus.tx_byte,         8'h00);
    checkOutput("t6_tx_last", {7'b0, bus.tx_last}, 8'h00);
    checkOutput("t6_overrun", {7'b0, bus.overrun}, 8'h00);
    reset = 1'b0;
    bus.load = 1'b0;
    tick(4);
    checkOutput("t6_idle_done", {7'b0, bus.done}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
